// File: rtl/cnn_layer_accel_host_pkg.sv
// rtl/cnn_layer_accel_host_pkg.sv - shared types and constants for the quad host job controller
package cnn_layer_accel_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FETCH,
    LOAD,
    WAIT_DONE,
    DRAIN,
    ACK
  } host_state_t;

  localparam int C_LANES      = 8;
  localparam int C_LANE_IDX_W = $clog2(C_LANES);
  localparam int C_WORD_W     = 128;

  typedef struct packed {
    logic                last;
    logic [C_WORD_W-1:0] data;
  } res_word_t;

endpackage

// File: rtl/cnn_layer_accel_host_res_fifo.sv
// rtl/cnn_layer_accel_host_res_fifo.sv - two-entry valid/ready FIFO for packed result words
module cnn_layer_accel_host_res_fifo #(
  parameter int C_WIDTH = 129
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_tvalid,
  output logic               in_tready,
  input  logic [C_WIDTH-1:0] in_tdata,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic [C_WIDTH-1:0] out_tdata
);

  logic [C_WIDTH-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic               push;
  logic               pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign out_tvalid = (count_q != 2'd0);
  assign in_tready  = (count_q != 2'd2) || out_tready;
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;
  assign out_tdata  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_tdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cnn_layer_accel_host_job_ctrl.sv
// rtl/cnn_layer_accel_host_job_ctrl.sv - host-side job initiator and result packer for one quad
module cnn_layer_accel_host_job_ctrl
  import cnn_layer_accel_host_pkg::*;
#(
  parameter int C_RES_WIDTH = 16,
  parameter int C_OUT_WIDTH = 128,
  parameter int C_CNT_WIDTH = 24
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [127:0]           cmd_parameters,
  input  logic [C_CNT_WIDTH-1:0] cmd_num_results,
  output logic                   job_start,
  input  logic                   job_accept,
  output logic [127:0]           job_parameters,
  input  logic                   job_fetch_request,
  output logic                   job_fetch_ack,
  output logic                   job_fetch_complete,
  input  logic                   job_complete,
  output logic                   job_complete_ack,
  output logic                   load_start,
  input  logic                   load_done,
  input  logic                   result_valid,
  output logic                   result_accept,
  input  logic [C_RES_WIDTH-1:0] result_data,
  output logic                   res_out_valid,
  input  logic                   res_out_ready,
  output logic [C_OUT_WIDTH-1:0] res_out_data,
  output logic                   res_out_last,
  output logic                   busy,
  output logic                   err_count_mismatch
);

  localparam logic [C_LANE_IDX_W-1:0] C_LAST_LANE = C_LANE_IDX_W'(C_LANES - 1);

  host_state_t             state_q, state_d;
  logic [C_LANE_IDX_W-1:0] idx_q;
  logic [C_OUT_WIDTH-1:0]  pack_q, pack_wr;
  logic [C_CNT_WIDTH-1:0]  cnt_q, cnt_inc, exp_q;
  logic [127:0]            params_q;
  logic                    err_q, pend_q, fetch_ack_q, fetch_cmp_q;
  logic                    cmd_fire, res_active, res_fire, wrap_push, drain_push;
  logic                    fifo_in_valid, fifo_in_ready;
  res_word_t               fifo_in, fifo_out;

  assign cmd_fire   = (state_q == IDLE) && cmd_valid;
  assign res_active = (state_q == WAIT_FETCH) || (state_q == LOAD) || (state_q == WAIT_DONE);
  assign res_fire   = result_valid && result_accept;
  assign wrap_push  = res_fire && (idx_q == C_LAST_LANE);
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // A completed word already flagged last (count hit the expected value on a wrap)
  // needs no extra push; otherwise drain emits a partial word or a zero marker word.
  assign drain_push = (state_q == DRAIN) &&
                      ((idx_q != '0) || (cnt_q == '0) || (cnt_q != exp_q));

  // Current pack register with the incoming result dropped into its lane.
  always_comb begin
    pack_wr = pack_q;
    pack_wr[int'(idx_q)*C_RES_WIDTH +: C_RES_WIDTH] = result_data;
  end

  assign fifo_in_valid = wrap_push || drain_push;
  assign fifo_in.last  = drain_push ? 1'b1 : (cnt_inc == exp_q);
  assign fifo_in.data  = drain_push ? pack_q : pack_wr;

  assign result_accept      = res_active && ((idx_q != C_LAST_LANE) || fifo_in_ready);
  assign cmd_ready          = (state_q == IDLE) && !rst;
  assign job_start          = (state_q == START);
  assign job_complete_ack   = (state_q == ACK);
  assign busy               = (state_q != IDLE);
  assign job_parameters     = params_q;
  assign job_fetch_ack      = fetch_ack_q;
  assign load_start         = fetch_ack_q;
  assign job_fetch_complete = fetch_cmp_q;
  assign err_count_mismatch = err_q;
  assign res_out_data       = fifo_out.data;
  assign res_out_last       = fifo_out.last;

  // Job handshake state register.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Job handshake next-state; completion seen during LOAD waits for load_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (cmd_valid)                     state_d = START;
      START:      if (job_accept)                    state_d = WAIT_FETCH;
      WAIT_FETCH: if (job_fetch_request)             state_d = LOAD;
      LOAD:       if (load_done)                     state_d = WAIT_DONE;
      WAIT_DONE:  if (job_complete || pend_q)        state_d = DRAIN;
      DRAIN:      if (!drain_push || fifo_in_ready)  state_d = ACK;
      ACK:        if (!job_complete)                 state_d = IDLE;
      default:                                       state_d = IDLE;
    endcase
  end

  // Job bookkeeping: parameters, expected count, one-cycle pulses, early completion, error flag.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      params_q    <= '0;
      exp_q       <= '0;
      fetch_ack_q <= 1'b0;
      fetch_cmp_q <= 1'b0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fetch_ack_q <= (state_q == WAIT_FETCH) && job_fetch_request;
      fetch_cmp_q <= (state_q == LOAD) && load_done;
      if (cmd_fire) begin
        params_q <= cmd_parameters;
        exp_q    <= cmd_num_results;
        pend_q   <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if ((state_q == LOAD) && job_complete) pend_q <= 1'b1;
        if ((state_q == DRAIN) && (cnt_q != exp_q)) err_q <= 1'b1;
      end
    end
  end

  // Result packing: lane index, pack register and saturating result counter.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      pack_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (cmd_fire) cnt_q <= '0;
      else if (res_fire) cnt_q <= cnt_inc;
      if (cmd_fire || (drain_push && fifo_in_ready) || wrap_push) begin
        idx_q  <= '0;
        pack_q <= '0;
      end else if (res_fire) begin
        idx_q  <= idx_q + 1'b1;
        pack_q <= pack_wr;
      end
    end
  end

  cnn_layer_accel_host_res_fifo #(
    .C_WIDTH($bits(res_word_t))
  ) u_res_fifo (
    .clk        (clk_if),
    .rst        (rst),
    .in_tvalid  (fifo_in_valid),
    .in_tready  (fifo_in_ready),
    .in_tdata   (fifo_in),
    .out_tvalid (res_out_valid),
    .out_tready (res_out_ready),
    .out_tdata  (fifo_out)
  );

endmodule

// File: tb/tb_cnn_layer_accel_host_job_ctrl.sv
// tb/tb_cnn_layer_accel_host_job_ctrl.sv - randomized self-checking bench for the host job controller
`timescale 1ns/1ps
module tb_cnn_layer_accel_host_job_ctrl;

  localparam int C_RES_WIDTH = 16;
  localparam int C_OUT_WIDTH = 128;
  localparam int C_CNT_WIDTH = 24;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_EARLY  = 1;
  localparam int MODE_STALL  = 2;
  localparam int MODE_RESET  = 3;

  logic                   clk_if = 1'b0;
  logic                   rst = 1'b1;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [127:0]           cmd_parameters = '0;
  logic [C_CNT_WIDTH-1:0] cmd_num_results = '0;
  logic                   job_start;
  logic                   job_accept = 1'b0;
  logic [127:0]           job_parameters;
  logic                   job_fetch_request = 1'b0;
  logic                   job_fetch_ack;
  logic                   job_fetch_complete;
  logic                   job_complete = 1'b0;
  logic                   job_complete_ack;
  logic                   load_start;
  logic                   load_done = 1'b0;
  logic                   result_valid = 1'b0;
  logic                   result_accept;
  logic [C_RES_WIDTH-1:0] result_data = '0;
  logic                   res_out_valid;
  logic                   res_out_ready = 1'b0;
  logic [C_OUT_WIDTH-1:0] res_out_data;
  logic                   res_out_last;
  logic                   busy;
  logic                   err_count_mismatch;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_host_job_ctrl #(
    .C_RES_WIDTH(C_RES_WIDTH),
    .C_OUT_WIDTH(C_OUT_WIDTH),
    .C_CNT_WIDTH(C_CNT_WIDTH)
  ) dut (
    .clk_if             (clk_if),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_parameters     (cmd_parameters),
    .cmd_num_results    (cmd_num_results),
    .job_start          (job_start),
    .job_accept         (job_accept),
    .job_parameters     (job_parameters),
    .job_fetch_request  (job_fetch_request),
    .job_fetch_ack      (job_fetch_ack),
    .job_fetch_complete (job_fetch_complete),
    .job_complete       (job_complete),
    .job_complete_ack   (job_complete_ack),
    .load_start         (load_start),
    .load_done          (load_done),
    .result_valid       (result_valid),
    .result_accept      (result_accept),
    .result_data        (result_data),
    .res_out_valid      (res_out_valid),
    .res_out_ready      (res_out_ready),
    .res_out_data       (res_out_data),
    .res_out_last       (res_out_last),
    .busy               (busy),
    .err_count_mismatch (err_count_mismatch)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [C_RES_WIDTH-1:0] job_res[$];
  logic [C_RES_WIDTH-1:0] src_q[$];
  logic [C_OUT_WIDTH:0]   exp_q[$];
  int  sink_mode = 0;
  bit  src_fire = 1'b0;
  int  n_accepted = 0;
  int  cnt_fetch_ack = 0;
  int  cnt_load_start = 0;
  int  cnt_fetch_cmp = 0;

  task automatic check_eq(input string tag, input logic [C_OUT_WIDTH:0] got, input logic [C_OUT_WIDTH:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference packing: eight results per word, lane 0 lowest, final word flagged last,
  // a zero marker word when nothing (or an off-count multiple of eight) arrived.
  function automatic void model_words(input int n_exp);
    logic [C_OUT_WIDTH-1:0] w;
    int lane;
    int n;
    w = '0;
    lane = 0;
    n = job_res.size();
    for (int i = 0; i < n; i++) begin
      w[lane*C_RES_WIDTH +: C_RES_WIDTH] = job_res[i];
      lane++;
      if (lane == 8) begin
        exp_q.push_back({(i + 1 == n_exp), w});
        w = '0;
        lane = 0;
      end
    end
    if (lane != 0 || n == 0 || n != n_exp) exp_q.push_back({1'b1, w});
  endfunction

  // Result source, output sink and pulse monitor; drives at negedge, samples 2 ns later.
  always @(negedge clk_if) begin
    if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() == 0) result_valid = 1'b0;
    else if (!result_valid || src_fire) result_valid = ($urandom_range(0, 3) != 0);
    result_data = (src_q.size() > 0) ? src_q[0] : '0;
    case (sink_mode)
      1:       res_out_ready = 1'b1;
      2:       res_out_ready = 1'b0;
      default: res_out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #2;
    src_fire = result_valid && result_accept;
    if (src_fire) n_accepted++;
    if (job_fetch_ack) cnt_fetch_ack++;
    if (load_start) cnt_load_start++;
    if (job_fetch_complete) cnt_fetch_cmp++;
    if (res_out_valid && res_out_ready) begin
      if (exp_q.size() == 0) check_eq("extra_word", 129'(res_out_valid), 129'(0));
      else check_eq("out_word", {res_out_last, res_out_data}, exp_q.pop_front());
    end
  end

  task automatic run_job(input int n_exp, input int mode, input int acc_dly, input int load_dly);
    logic [127:0] prm;
    bit ok;
    bit saw;
    int acc0;
    prm = {$urandom, $urandom, $urandom, $urandom};
    cnt_fetch_ack = 0;
    cnt_load_start = 0;
    cnt_fetch_cmp = 0;
    if (mode == MODE_STALL) sink_mode = 2;
    @(negedge clk_if);
    check_eq("cmd_ready_idle", 129'(cmd_ready), 129'(1));
    cmd_valid = 1'b1;
    cmd_parameters = prm;
    cmd_num_results = C_CNT_WIDTH'(n_exp);
    @(negedge clk_if);
    cmd_valid = 1'b0;
    check_eq("job_start", 129'(job_start), 129'(1));
    check_eq("job_params", 129'(job_parameters), 129'(prm));
    check_eq("err_cleared", 129'(err_count_mismatch), 129'(0));
    check_eq("busy_job", 129'(busy), 129'(1));
    repeat (acc_dly) @(negedge clk_if);
    check_eq("job_start_held", 129'(job_start), 129'(1));
    job_accept = 1'b1;
    @(negedge clk_if);
    job_accept = 1'b0;
    check_eq("job_start_drop", 129'(job_start), 129'(0));
    job_fetch_request = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk_if);
      ok = job_fetch_ack;
    end
    job_fetch_request = 1'b0;
    check_eq("fetch_ack", 129'(job_fetch_ack), 129'(1));
    check_eq("load_start", 129'(load_start), 129'(1));
    acc0 = n_accepted;
    if (mode != MODE_RESET) begin
      model_words(n_exp);
      foreach (job_res[i]) src_q.push_back(job_res[i]);
    end
    if (mode == MODE_STALL) begin
      repeat (40) @(negedge clk_if);
      check_eq("bp_accepted", 129'(n_accepted - acc0), 129'(23));
      check_eq("bp_accept_low", 129'(result_accept), 129'(0));
      check_eq("bp_out_valid", 129'(res_out_valid), 129'(1));
      sink_mode = 0;
    end
    if (mode == MODE_EARLY) begin
      for (int k = 0; k < 400 && src_q.size() != 0; k++) @(negedge clk_if);
      check_eq("early_src_done", 129'(src_q.size()), 129'(0));
      job_complete = 1'b1;
      repeat (3) @(negedge clk_if);
      check_eq("early_no_ack", 129'(job_complete_ack), 129'(0));
      check_eq("early_no_fcmp", 129'(cnt_fetch_cmp), 129'(0));
    end
    repeat (load_dly) @(negedge clk_if);
    load_done = 1'b1;
    @(negedge clk_if);
    load_done = 1'b0;
    check_eq("fetch_complete", 129'(job_fetch_complete), 129'(1));
    if (mode == MODE_RESET) begin
      foreach (job_res[i]) src_q.push_back(job_res[i]);
      for (int k = 0; k < 200 && src_q.size() != 0; k++) @(negedge clk_if);
      repeat (2) @(negedge clk_if);
      check_eq("rst_pre_accepted", 129'(n_accepted - acc0), 129'(job_res.size()));
      rst = 1'b1;
      src_q.delete();
      #1;
      check_eq("rst_mid_ctrl", 129'({cmd_ready, job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
                                     load_start, result_accept, res_out_valid, res_out_last, busy, err_count_mismatch}),
               129'(0));
      check_eq("rst_mid_params", 129'(job_parameters), 129'(0));
      check_eq("rst_mid_data", 129'(res_out_data), 129'(0));
      repeat (3) @(negedge clk_if);
      rst = 1'b0;
      saw = 1'b0;
      repeat (12) begin
        @(negedge clk_if);
        #3;
        if (res_out_valid || busy || job_start) saw = 1'b1;
      end
      check_eq("rst_no_activity", 129'(saw), 129'(0));
      return;
    end
    for (int k = 0; k < 2000 && src_q.size() != 0; k++) @(negedge clk_if);
    check_eq("src_drained", 129'(src_q.size()), 129'(0));
    repeat (2) @(negedge clk_if);
    job_complete = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk_if);
      ok = job_complete_ack;
    end
    check_eq("complete_ack", 129'(job_complete_ack), 129'(1));
    repeat (3) @(negedge clk_if);
    check_eq("ack_held", 129'(job_complete_ack), 129'(1));
    job_complete = 1'b0;
    @(negedge clk_if);
    check_eq("ack_drop", 129'(job_complete_ack), 129'(0));
    check_eq("busy_done", 129'(busy), 129'(0));
    check_eq("err_flag", 129'(err_count_mismatch), 129'(job_res.size() != n_exp));
    check_eq("fetch_ack_pulses", 129'(cnt_fetch_ack), 129'(1));
    check_eq("load_start_pulses", 129'(cnt_load_start), 129'(1));
    check_eq("fetch_cmp_pulses", 129'(cnt_fetch_cmp), 129'(1));
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk_if);
    check_eq("words_drained", 129'(exp_q.size()), 129'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int ne;
    repeat (3) @(negedge clk_if);
    #1;
    check_eq("reset_ctrl", 129'({cmd_ready, job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
                                 load_start, result_accept, res_out_valid, res_out_last, busy, err_count_mismatch}),
             129'(0));
    rst = 1'b0;
    @(negedge clk_if);
    check_eq("idle_ready", 129'({cmd_ready, busy}), 129'(2'b10));

    job_res.delete();
    for (int i = 1; i <= 16; i++) job_res.push_back(C_RES_WIDTH'(i));
    run_job(16, MODE_NORMAL, 3, 10);

    job_res.delete();
    for (int i = 0; i < 11; i++) job_res.push_back(C_RES_WIDTH'(16'hA000 + i));
    run_job(11, MODE_NORMAL, 1, 4);

    job_res.delete();
    for (int i = 0; i < 24; i++) job_res.push_back(C_RES_WIDTH'($urandom_range(0, 65535)));
    run_job(24, MODE_STALL, 2, 3);

    job_res.delete();
    for (int i = 0; i < 18; i++) job_res.push_back(C_RES_WIDTH'($urandom_range(0, 65535)));
    run_job(20, MODE_NORMAL, 0, 2);

    job_res.delete();
    for (int i = 0; i < 12; i++) job_res.push_back(C_RES_WIDTH'($urandom_range(0, 65535)));
    run_job(12, MODE_EARLY, 1, 6);

    job_res.delete();
    for (int i = 0; i < 5; i++) job_res.push_back(C_RES_WIDTH'($urandom_range(0, 65535)));
    run_job(10, MODE_RESET, 1, 2);

    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(0, 40);
      ne = n;
      if ((n % 8) != 0 && $urandom_range(0, 2) == 0) ne = n + $urandom_range(1, 3);
      job_res.delete();
      for (int i = 0; i < n; i++) job_res.push_back(C_RES_WIDTH'($urandom_range(0, 65535)));
      run_job(ne, ($urandom_range(0, 1) == 0) ? MODE_NORMAL : MODE_EARLY,
              $urandom_range(0, 4), $urandom_range(1, 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_host_job_ctrl.md
Name: cnn_layer_accel_host_job_ctrl

Overview:
- Host-side initiator for the cnn_layer_accel_quad job protocol: issues the job, answers the fetch request, kicks an external pixel/weight loader and acknowledges completion.
- Also acts as the receiver for the quad's 16-bit result stream and packs results into 128-bit words for the host write path.
- Sits between the host command FIFO and one quad instance, all on the interface clock.

Parameters:
- C_RES_WIDTH, 16, width of one quad result.
- C_OUT_WIDTH, 128, packed output word width; C_OUT_WIDTH/C_RES_WIDTH = 8 lanes.
- C_CNT_WIDTH, 24, width of the expected-result counter.

Ports:
- clk_if  in  1  interface clock; all logic on this clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host job command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_parameters  in  128  job parameter word.
- cmd_num_results  in  C_CNT_WIDTH  expected number of results for the job.
- job_start  out  1  job request to the quad.
- job_accept  in  1  quad accepted the job.
- job_parameters  out  128  registered copy of cmd_parameters.
- job_fetch_request  in  1  quad requests input data.
- job_fetch_ack  out  1  one-cycle acknowledge of the fetch request.
- job_fetch_complete  out  1  one-cycle pulse once loading is done.
- job_complete  in  1  quad finished the job.
- job_complete_ack  out  1  completion acknowledge.
- load_start  out  1  one-cycle pulse to the external loader.
- load_done  in  1  loader finished pixel and weight transfer.
- result_valid  in  1  quad result valid.
- result_accept  out  1  result consumed when result_valid & result_accept.
- result_data  in  C_RES_WIDTH  quad result.
- res_out_valid  out  1  packed word valid.
- res_out_ready  in  1  downstream ready.
- res_out_data  out  C_OUT_WIDTH  packed results; lane 0 in bits [15:0].
- res_out_last  out  1  final word of the job.
- busy  out  1  state != IDLE.
- err_count_mismatch  out  1  sticky; result count at job_complete != cmd_num_results.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, lane index 0, counter 0, output FIFO empty. Reset mid-job abandons the job with no further handshakes.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch parameters and expected count, clear err_count_mismatch, go to START.
- START:
  - job_start = 1 and held until job_accept is sampled high.
  - Then go to WAIT_FETCH; job_start = 0 from the next cycle.
- WAIT_FETCH:
  - On job_fetch_request: job_fetch_ack = 1 and load_start = 1 for exactly one cycle, then go to LOAD.
- LOAD:
  - On load_done: job_fetch_complete = 1 for one cycle, then go to WAIT_DONE.
  - If job_complete arrives in LOAD, it is held pending until load_done is handled.
- WAIT_DONE: on job_complete, go to DRAIN.
- DRAIN:
  - If the lane index is nonzero, push the partial word with unused lanes zeroed.
  - Otherwise, mark the last pushed word as last; if no results were received, push one all-zero word.
  - res_out_last = 1 on that final word only.
  - Compare the result counter with the expected count and set err_count_mismatch on difference.
  - Go to ACK once the push is accepted by the FIFO.
- ACK:
  - job_complete_ack = 1 until job_complete is sampled low, then go to IDLE.
  - The FIFO may still be draining; the next command may start regardless.
- Result path:
  - result_accept = (state in WAIT_FETCH, LOAD, WAIT_DONE) & FIFO has a free entry, or the pack register is not yet full.
  - Each accepted result is written into lane[index]; index increments and wraps 7 -> 0.
  - On wrap, the full word is pushed to the FIFO in the same cycle.
  - If the FIFO is full, result_accept = 0 while index == 7.
  - The result counter saturates at all ones.
- Output FIFO:
  - 2 entries, 129 bits (data + last); res_out_valid = not empty.
  - Simultaneous push and pop when full is allowed.
- Latency: an accepted 8th result appears on res_out_data the next cycle if the FIFO was empty.

Decomposition:
- Package cnn_layer_accel_host_pkg holds:
  - FSM enum: IDLE, START, WAIT_FETCH, LOAD, WAIT_DONE, DRAIN, ACK.
  - Lane-count constant.
  - Packed-word struct {last, data}.
- Sub-module cnn_layer_accel_host_res_fifo: 2-deep valid/ready FIFO with parameterised width.

Test Plan:
- Basic job:
  - Stimulus: cmd_num_results = 16; job_accept 3 cycles after job_start; fetch request; load_done after 10 cycles; 16 results 1..16; job_complete.
  - Response: two words; word0 lanes = 1..8, word1 lanes = 9..16 with last = 1; err = 0; job_complete_ack held until job_complete drops.
- Partial word:
  - Stimulus: 11 results 0xA000..0xA00A, expected 11.
  - Response: word1 lanes 0..2 = 0xA008..0xA00A, lanes 3..7 = 0, last = 1.
- Backpressure:
  - Stimulus: res_out_ready = 0 for 40 cycles while 24 results are offered.
  - Response: result_accept drops once 2 words are queued plus the pack register is full; no result lost or duplicated after ready returns.
- Mismatch:
  - Stimulus: expected 20, quad sends 18.
  - Response: err_count_mismatch = 1 after DRAIN; cleared when the next command is accepted.
- Early complete:
  - Stimulus: job_complete asserted during LOAD.
  - Response: job_fetch_complete still pulses after load_done, then DRAIN and ACK in order.
- Reset mid-job:
  - Stimulus: rst asserted in WAIT_DONE with 5 results buffered.
  - Response: all outputs 0 immediately; no res_out_valid after reset; the next command runs normally.
